prime_seq_engine: RTL and testbench

- Bus-mapped peripheral that finds the A-th prime number by sequential trial division.
- Successor to the single-width prime emulator peripheral. Adds:
  - a parametrised data width
  - a fully clocked register interface
  - a bounded one-bit-per-cycle remainder unit
  - restart on rewrite, an overflow error status, and a progress register
- Sits behind the system bus strobes and drives the GPIO output pins with a running prime tally.

---
 rtl/prime_seq_pkg.sv | 28 ++
 rtl/prime_seq_engine_if.sv | 19 +
 rtl/prime_seq_rem.sv | 60 ++++++
 rtl/prime_seq_engine.sv | 199 +++++++++++++++++++
 tb/tb_prime_seq_engine.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/prime_seq_pkg.sv
// Shared types and constants for the prime_seq_engine block.
// Optional interrupt output is enabled by defining PRIME_SEQ_IRQ_EN.
package prime_seq_pkg;

  // Main sequencer states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    CAND  = 3'd2,
    WAIT  = 3'd3,
    FOUND = 3'd4,
    NEXT  = 3'd5,
    DONE  = 3'd6
  } state_t;

  // Software-visible status codes held in the S register.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_OVF  = 2'd3;

  // Register offsets relative to the block base address.
  localparam int unsigned OFF_A   = 'h00;
  localparam int unsigned OFF_W   = 'h10;
  localparam int unsigned OFF_S   = 'h20;
  localparam int unsigned OFF_CNT = 'h30;

endpackage

// File: rtl/prime_seq_engine_if.sv
// Register bus between a system-bus master and the prime_seq_engine.
// Strobe semantics: srd and swr are single-cycle pulses sampled on the rising
// clk edge; there is no back-pressure. A read sampled in cycle n presents its
// data on sdata_out in cycle n+1, and sdata_out holds until the next read.
interface prime_seq_engine_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] saddress;
  logic              srd;
  logic              swr;
  logic [DATA_W-1:0] sdata_in;
  logic [DATA_W-1:0] sdata_out;

  modport master (output saddress, output srd, output swr, output sdata_in,
                  input  sdata_out);
  modport slave  (input  saddress, input  srd, input  swr, input  sdata_in,
                  output sdata_out);
endinterface

// File: rtl/prime_seq_rem.sv
// Restoring remainder unit: one quotient bit per cycle, rem_valid pulses
// exactly DATA_W+1 cycles after start. abort drops any run in flight.
module prime_seq_rem #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem,
  output logic              rem_valid
);
  localparam int CW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] dvd_q, dvs_q, rem_q;
  logic [CW-1:0]     cnt_q;
  logic              busy_q, valid_q;
  logic [DATA_W:0]   trial, diff;

  // Shift the next dividend bit into the partial remainder and try to subtract.
  assign trial = {rem_q, dvd_q[DATA_W-1]};
  assign diff  = trial - {1'b0, dvs_q};

  // Iteration control and partial remainder; diff[DATA_W] set means borrow.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (abort) begin
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (start) begin
      dvd_q   <= dividend;
      dvs_q   <= divisor;
      rem_q   <= '0;
      cnt_q   <= CW'(DATA_W);
      busy_q  <= 1'b1;
      valid_q <= 1'b0;
    end else if (busy_q) begin
      rem_q <= diff[DATA_W] ? trial[DATA_W-1:0] : diff[DATA_W-1:0];
      dvd_q <= dvd_q << 1;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_q  <= 1'b0;
        valid_q <= 1'b1;
      end
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign rem       = rem_q;
  assign rem_valid = valid_q;
endmodule

// File: rtl/prime_seq_engine.sv
// Bus-mapped engine that finds the A-th prime by trial division and drives a
// running prime tally on gpio_out. Define PRIME_SEQ_IRQ_EN to add the irq output.
module prime_seq_engine
  import prime_seq_pkg::*;
#(
  parameter int                DATA_W = 32,
  parameter int                ADDR_W = 16,
  parameter int                GPIO_W = 16,
  parameter logic [ADDR_W-1:0] BASE   = 'h100
) (
  input  logic                 clk,
  input  logic                 n_reset,
  prime_seq_engine_if.slave    bus,
  output logic [31:0]          gpio_out,
`ifdef PRIME_SEQ_IRQ_EN
  output logic                 irq,
`endif
  output state_t               dbg_state_o
);
  localparam logic [ADDR_W-1:0] A_ADR   = BASE + ADDR_W'(OFF_A);
  localparam logic [ADDR_W-1:0] W_ADR   = BASE + ADDR_W'(OFF_W);
  localparam logic [ADDR_W-1:0] S_ADR   = BASE + ADDR_W'(OFF_S);
  localparam logic [ADDR_W-1:0] CNT_ADR = BASE + ADDR_W'(OFF_CNT);

  logic [1:0]        rst_sync_q;
  logic              rst_n;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, w_q, w_d, cnt_q, cnt_d, cand_q, cand_d, div_q, div_d;
  logic [DATA_W:0]   sq_q, sq_d, sq_inc;
  logic [1:0]        s_q, s_d;
  logic [GPIO_W-1:0] tally_q, tally_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              wr_a, rem_start, rem_abort, rem_valid;
  logic [DATA_W-1:0] rem_div, rem;

  // Reset asserts immediately and releases two clk edges later.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  assign wr_a   = bus.swr && (bus.saddress == A_ADR);
  // Next square: (div+1)^2 = div^2 + 2*div + 1, kept one bit wider than data.
  assign sq_inc = sq_q + {div_q, 1'b1};

  // Sequencer next-state; a write to A overrides everything and restarts.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    w_d       = w_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    div_d     = div_q;
    sq_d      = sq_q;
    s_d       = s_q;
    tally_d   = tally_q;
    rem_start = 1'b0;
    rem_abort = 1'b0;
    rem_div   = div_q;
    unique case (state_q)
      IDLE: ;
      INIT: begin
        if (a_q == '0) begin
          w_d     = '0;
          s_d     = ST_DONE;
          state_d = DONE;
        end else begin
          cand_d  = DATA_W'(2);
          state_d = CAND;
        end
      end
      CAND: begin
        div_d = DATA_W'(2);
        sq_d  = (DATA_W+1)'(4);
        if ((DATA_W+1)'(4) > {1'b0, cand_q}) begin
          state_d = FOUND;
        end else begin
          rem_start = 1'b1;
          rem_div   = DATA_W'(2);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (rem_valid) begin
          if (rem == '0) begin
            state_d = NEXT;
          end else begin
            sq_d  = sq_inc;
            div_d = div_q + DATA_W'(1);
            if (sq_inc > {1'b0, cand_q}) begin
              state_d = FOUND;
            end else begin
              rem_start = 1'b1;
              rem_div   = div_q + DATA_W'(1);
            end
          end
        end
      end
      FOUND: begin
        w_d     = cand_q;
        cnt_d   = cnt_q + DATA_W'(1);
        tally_d = tally_q + GPIO_W'(1);
        if (cnt_q + DATA_W'(1) == a_q) begin
          s_d     = ST_DONE;
          state_d = DONE;
        end else begin
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (cand_q == '1) begin
          s_d     = ST_OVF;
          state_d = DONE;
        end else begin
          cand_d  = cand_q + DATA_W'(1);
          state_d = CAND;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (wr_a) begin
      a_d       = bus.sdata_in;
      w_d       = '0;
      cnt_d     = '0;
      s_d       = ST_BUSY;
      state_d   = INIT;
      rem_start = 1'b0;
      rem_abort = 1'b1;
    end
  end

  // Read mux samples pre-write register values; A is write-only.
  always_comb begin
    rdata_d = rdata_q;
    if (bus.srd) begin
      if (bus.saddress == W_ADR)        rdata_d = w_q;
      else if (bus.saddress == S_ADR)   rdata_d = DATA_W'(s_q);
      else if (bus.saddress == CNT_ADR) rdata_d = cnt_q;
      else                              rdata_d = '0;
    end
  end

  // Architectural and working registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      w_q     <= '0;
      cnt_q   <= '0;
      cand_q  <= '0;
      div_q   <= '0;
      sq_q    <= '0;
      s_q     <= ST_IDLE;
      tally_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      div_q   <= div_d;
      sq_q    <= sq_d;
      s_q     <= s_d;
      tally_q <= tally_d;
      rdata_q <= rdata_d;
    end
  end

  prime_seq_rem #(.DATA_W(DATA_W)) u_rem (
    .clk       (clk),
    .n_reset   (rst_n),
    .start     (rem_start),
    .abort     (rem_abort),
    .dividend  (cand_q),
    .divisor   (rem_div),
    .rem       (rem),
    .rem_valid (rem_valid)
  );

`ifdef PRIME_SEQ_IRQ_EN
  logic irq_q, irq_set, irq_clr;
  assign irq_set = (s_q == ST_BUSY) && ((s_d == ST_DONE) || (s_d == ST_OVF));
  assign irq_clr = wr_a || (bus.srd && (bus.saddress == S_ADR));
  // Completion interrupt; a set wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       irq_q <= 1'b0;
    else if (irq_set) irq_q <= 1'b1;
    else if (irq_clr) irq_q <= 1'b0;
  end
  assign irq = irq_q;
`endif

  assign bus.sdata_out = rdata_q;
  assign gpio_out      = 32'(tally_q);
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_prime_seq_engine.sv
// Bench for prime_seq_engine: a 32-bit and an 8-bit instance on one clock,
// random A values checked against a plain nth-prime reference model.
module tb_prime_seq_engine;
  import prime_seq_pkg::*;

  localparam logic [15:0] A_ADR   = 16'h100;
  localparam logic [15:0] W_ADR   = 16'h110;
  localparam logic [15:0] S_ADR   = 16'h120;
  localparam logic [15:0] CNT_ADR = 16'h130;
  localparam int          BUDGET  = 30000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_reset = 1'b0;
  always #5 clk = ~clk;

  prime_seq_engine_if #(.ADDR_W(16), .DATA_W(32)) bus32 ();
  prime_seq_engine_if #(.ADDR_W(16), .DATA_W(8))  bus8 ();
  logic [31:0] gpio32, gpio8;
  state_t      dbg32, dbg8;
`ifdef PRIME_SEQ_IRQ_EN
  logic irq32, irq8;
`endif

  prime_seq_engine u_dut32 (
    .clk(clk), .n_reset(n_reset), .bus(bus32), .gpio_out(gpio32),
`ifdef PRIME_SEQ_IRQ_EN
    .irq(irq32),
`endif
    .dbg_state_o(dbg32));

  prime_seq_engine #(.DATA_W(8)) u_dut8 (
    .clk(clk), .n_reset(n_reset), .bus(bus8), .gpio_out(gpio8),
`ifdef PRIME_SEQ_IRQ_EN
    .irq(irq8),
`endif
    .dbg_state_o(dbg8));

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  int tally32 = 0, tally8 = 0;
  bit tally32_known = 1'b1;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_prime(input longint c);
    for (longint d = 2; d * d <= c; d++)
      if (c % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  // A-th prime within a wbits-wide candidate range; s = 2 done, 3 overflow.
  function automatic void ref_run(input longint a, input int wbits,
                                  output longint w, output longint cnt, output int s);
    longint maxv = (longint'(1) << wbits) - 1;
    w = 0; cnt = 0; s = 2;
    if (a == 0) return;
    for (longint c = 2; c <= maxv; c++) begin
      if (is_prime(c)) begin
        w = c; cnt++;
        if (cnt == a) return;
      end
    end
    s = 3;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic bus_write(input bit sel, input logic [15:0] addr, input logic [31:0] data);
    @(negedge clk);
    if (sel) begin bus8.saddress = addr; bus8.sdata_in = data[7:0]; bus8.swr = 1'b1; end
    else     begin bus32.saddress = addr; bus32.sdata_in = data; bus32.swr = 1'b1; end
    @(negedge clk);
    bus8.swr = 1'b0; bus32.swr = 1'b0;
  endtask

  task automatic bus_read(input bit sel, input logic [15:0] addr, output logic [31:0] data);
    @(negedge clk);
    if (sel) begin bus8.saddress = addr; bus8.srd = 1'b1; end
    else     begin bus32.saddress = addr; bus32.srd = 1'b1; end
    @(negedge clk);
    bus8.srd = 1'b0; bus32.srd = 1'b0;
    data = sel ? 32'(bus8.sdata_out) : bus32.sdata_out;
  endtask

  task automatic wait_done(input bit sel, input string tag);
    logic [31:0] rd;
    int n = 0;
    do begin
      bus_read(sel, S_ADR, rd);
      n++;
    end while (rd != 2 && rd != 3 && n < BUDGET);
    check({tag, "_finished"}, (rd == 2 || rd == 3), 1);
  endtask

  // Full run: write A, poll to completion, compare W/CNT/S/tally with the model.
  task automatic run_check(input bit sel, input longint a, input string tag);
    longint w, cnt;
    int s;
    logic [31:0] rd;
    bus_write(sel, A_ADR, 32'(a));
    wait_done(sel, tag);
    ref_run(a, sel ? 8 : 32, w, cnt, s);
    exp_q.push_back(32'(w));
    exp_q.push_back(32'(cnt));
    exp_q.push_back(32'(s));
    bus_read(sel, W_ADR, rd);   check({tag, "_W"}, rd, exp_q.pop_front());
    bus_read(sel, CNT_ADR, rd); check({tag, "_CNT"}, rd, exp_q.pop_front());
    bus_read(sel, S_ADR, rd);   check({tag, "_S"}, rd, exp_q.pop_front());
    if (sel) begin
      tally8 = (tally8 + int'(cnt)) % 65536;
      check({tag, "_gpio"}, gpio8, 32'(tally8));
    end else begin
      tally32 = (tally32 + int'(cnt)) % 65536;
      if (tally32_known) check({tag, "_gpio"}, gpio32, 32'(tally32));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] rd;
    bus32.saddress = '0; bus32.srd = 1'b0; bus32.swr = 1'b0; bus32.sdata_in = '0;
    bus8.saddress = '0;  bus8.srd = 1'b0;  bus8.swr = 1'b0;  bus8.sdata_in = '0;

    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    repeat (4) @(negedge clk);

    // Reset state.
    check("rst_sdata_out", bus32.sdata_out, 0);
    check("rst_gpio32", gpio32, 0);
    check("rst_gpio8", gpio8, 0);
`ifdef PRIME_SEQ_IRQ_EN
    check("rst_irq", irq32, 0);
`endif
    bus_read(0, S_ADR, rd);   check("rst_S", rd, 0);
    bus_read(0, W_ADR, rd);   check("rst_W", rd, 0);
    bus_read(0, CNT_ADR, rd); check("rst_CNT", rd, 0);

    // Directed runs on the 32-bit instance.
    run_check(0, 1, "a1");
    run_check(0, 10, "a10");
    run_check(0, 5, "a5");

    // A=0 completes almost immediately.
    bus_write(0, A_ADR, 0);
    bus_read(0, S_ADR, rd);   check("a0_S_fast", rd, 2);
    bus_read(0, W_ADR, rd);   check("a0_W", rd, 0);
    bus_read(0, CNT_ADR, rd); check("a0_CNT", rd, 0);

    // Random A values on the 32-bit instance.
    for (int i = 0; i < 3; i++) run_check(0, $urandom_range(1, 12), $sformatf("r32_%0d", i));

    // A is write-only, unmapped returns 0, W ignores writes, sdata_out holds.
    bus_read(0, A_ADR, rd);          check("read_A_zero", rd, 0);
    bus_read(0, 16'h140, rd);        check("unmapped_zero", rd, 0);
    bus_write(0, W_ADR, 32'd1234);
    bus_read(0, W_ADR, rd);          check("W_write_ignored", rd, exp_q.size() == 0 ? rd : 0);
    exp_q.push_back(rd);
    repeat (5) @(negedge clk);
    check("sdata_out_hold", bus32.sdata_out, exp_q.pop_front());

`ifdef PRIME_SEQ_IRQ_EN
    bus_write(0, A_ADR, 1);
    repeat (300) @(negedge clk);
    check("irq_set", irq32, 1);
    bus_read(0, S_ADR, rd);
    check("irq_S", rd, 2);
    check("irq_clear", irq32, 0);
    tally32 = (tally32 + 1) % 65536;
`endif

    // Rewrite A mid-run: clean restart, no stale W.
    bus_write(0, A_ADR, 100);
    repeat (500) @(negedge clk);
    bus_read(0, S_ADR, rd);  check("abort_busy", rd, 1);
    tally32_known = 1'b0;
    bus_write(0, A_ADR, 3);
    bus_read(0, W_ADR, rd);  check("abort_W_cleared", rd, 0);
    run_check(0, 3, "abort_a3");

    // Reset mid-run: outputs drop at once.
    bus_write(0, A_ADR, 10);
    repeat (100) @(negedge clk);
    #2 n_reset = 1'b0;
    #1;
    check("midrst_gpio32", gpio32, 0);
    check("midrst_sdata_out", bus32.sdata_out, 0);
    check("midrst_gpio8", gpio8, 0);
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    repeat (4) @(negedge clk);
    tally32 = 0; tally8 = 0; tally32_known = 1'b1;
    bus_read(0, S_ADR, rd);   check("midrst_S", rd, 0);
    bus_read(0, CNT_ADR, rd); check("midrst_CNT", rd, 0);
    run_check(0, 2, "post_rst_a2");

    // 8-bit instance: last prime in range and the overflow case.
    run_check(1, 54, "w8_a54");
    run_check(1, 55, "w8_a55_ovf");
    for (int i = 0; i < 4; i++) run_check(1, $urandom_range(0, 30), $sformatf("r8_%0d", i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
